// File: rtl/fsm_arb.sv
// fsm_arb: round-robin arbiter feeding an IDLE/READ/WRITE/TOUT transaction FSM
// Ports: clk, reset (async, active-high); req/we per channel; ack from target;
// idle/read/write/timeout decoded from state; gnt one-hot grant while busy;
// gnt_id index of the last granted channel.
module fsm_arb #(
  parameter int N_CH = 4,
  parameter int TMO  = 16,
  localparam int IW  = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N_CH-1:0] req,
  input  logic [N_CH-1:0] we,
  input  logic            ack,
  output logic            idle,
  output logic            read,
  output logic            write,
  output logic [N_CH-1:0] gnt,
  output logic [IW-1:0]   gnt_id,
  output logic            timeout
);
  typedef enum logic [1:0] {IDLE, READ, WRITE, TOUT} state_t;
  state_t state, nxt;
  logic [N_CH-1:0] gnt_r;
  logic [IW-1:0] ptr, win, idx;
  logic [7:0] cnt;
  logic busy;
  assign busy = (state == READ) || (state == WRITE);
  // Scan from farthest to nearest so the channel closest after ptr wins.
  always_comb begin
    win = '0;
    idx = '0;
    for (int i = N_CH; i >= 1; i--) begin
      idx = IW'((int'(ptr) + i) % N_CH);
      if (req[idx]) win = idx;
    end
  end
  always_comb begin
    nxt = state;
    case (state)
      IDLE:       nxt = |req ? (we[win] ? WRITE : READ) : IDLE;
      READ, WRITE: nxt = ack ? IDLE : (cnt == 8'(TMO - 1)) ? TOUT : state;
      default:    nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      gnt_r  <= '0;
      gnt_id <= '0;
      ptr    <= IW'(N_CH - 1);
      cnt    <= '0;
    end else begin
      state <= nxt;
      if (state == IDLE && |req) begin
        gnt_r  <= N_CH'(1) << win;
        gnt_id <= win;
        ptr    <= win;
        cnt    <= '0;
      end else if (busy && !ack) begin
        cnt <= cnt + 8'd1;
      end
    end
  end
  assign idle    = state == IDLE;
  assign read    = state == READ;
  assign write   = state == WRITE;
  assign timeout = state == TOUT;
  assign gnt     = busy ? gnt_r : '0;
endmodule

// File: tb/tb_fsm_arb.sv
// tb_fsm_arb: directed checks of fsm_arb with N_CH=4, TMO=4
module tb_fsm_arb;
  logic clk, reset, ack, idle, read, write, timeout;
  logic [3:0] req, we, gnt;
  logic [1:0] gnt_id;
  logic [9:0] obs;
  int checks = 0, failures = 0;
  fsm_arb #(.N_CH(4), .TMO(4)) dut (
    .clk(clk), .reset(reset), .req(req), .we(we), .ack(ack),
    .idle(idle), .read(read), .write(write), .gnt(gnt),
    .gnt_id(gnt_id), .timeout(timeout)
  );
  assign obs = {idle, read, write, timeout, gnt, gnt_id};
  initial clk = 0;
  always #5 clk = ~clk;
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset;
    reset = 1; req = 0; we = 0; ack = 0;
    #1;
    checks++;
    if (obs !== 10'b1000_0000_00) begin failures++; $display("FAIL reset_async obs=%b exp=%b", obs, 10'b1000_0000_00); end
    repeat (2) @(posedge clk);
    #1 reset = 0;
    for (int c = 0; c < 3; c++) begin
      step;
      checks++;
      if (obs !== 10'b1000_0000_00) begin failures++; $display("FAIL reset_idle cyc=%0d obs=%b exp=%b", c, obs, 10'b1000_0000_00); end
    end
  endtask
  task automatic test_single;
    req = 4'b0001; we = 0;
    step;
    req = 0; ack = 1;
    checks++;
    if (obs !== 10'b0100_0001_00) begin failures++; $display("FAIL single_read obs=%b exp=%b", obs, 10'b0100_0001_00); end
    step;
    ack = 0;
    checks++;
    if (obs !== 10'b1000_0000_00) begin failures++; $display("FAIL single_idle obs=%b exp=%b", obs, 10'b1000_0000_00); end
  endtask
  task automatic test_round_robin;
    int seq [5] = '{0, 1, 2, 3, 0};
    logic [9:0] e;
    reset = 1;
    #1 reset = 0;
    req = 4'b1111; we = 4'b0100; ack = 1;
    for (int k = 0; k < 5; k++) begin
      step;
      e = {1'b0, seq[k] != 2, seq[k] == 2, 1'b0, 4'(1 << seq[k]), 2'(seq[k])};
      if (k == 4) req = 0;
      checks++;
      if (obs !== e) begin failures++; $display("FAIL rr_grant k=%0d obs=%b exp=%b", k, obs, e); end
      step;
      e = {4'b1000, 4'b0000, 2'(seq[k])};
      checks++;
      if (obs !== e) begin failures++; $display("FAIL rr_idle k=%0d obs=%b exp=%b", k, obs, e); end
    end
    ack = 0;
  endtask
  task automatic test_timeout;
    req = 4'b0010; we = 4'b0010; ack = 0;
    for (int c = 0; c < 4; c++) begin
      step;
      req = 4'b1101; we = 4'b0000;
      checks++;
      if (obs !== 10'b0010_0010_01) begin failures++; $display("FAIL tmo_write cyc=%0d obs=%b exp=%b", c, obs, 10'b0010_0010_01); end
    end
    req = 0;
    step;
    checks++;
    if (obs !== 10'b0001_0000_01) begin failures++; $display("FAIL tmo_pulse obs=%b exp=%b", obs, 10'b0001_0000_01); end
    step;
    checks++;
    if (obs !== 10'b1000_0000_01) begin failures++; $display("FAIL tmo_idle obs=%b exp=%b", obs, 10'b1000_0000_01); end
  endtask
  task automatic test_ack_wins;
    req = 4'b0010; we = 4'b0010; ack = 0;
    for (int c = 0; c < 4; c++) begin
      step;
      req = 0;
      if (c == 3) ack = 1;
      checks++;
      if (obs !== 10'b0010_0010_01) begin failures++; $display("FAIL ackw_write cyc=%0d obs=%b exp=%b", c, obs, 10'b0010_0010_01); end
    end
    step;
    checks++;
    if (obs !== 10'b1000_0000_01) begin failures++; $display("FAIL ackw_idle obs=%b exp=%b", obs, 10'b1000_0000_01); end
    step;
    ack = 0;
    checks++;
    if (obs !== 10'b1000_0000_01) begin failures++; $display("FAIL ack_in_idle obs=%b exp=%b", obs, 10'b1000_0000_01); end
  endtask
  task automatic test_reset_mid;
    req = 4'b0100; we = 4'b0100;
    step;
    req = 0; we = 0;
    checks++;
    if (obs !== 10'b0010_0100_10) begin failures++; $display("FAIL mid_write obs=%b exp=%b", obs, 10'b0010_0100_10); end
    #2 reset = 1;
    #1;
    checks++;
    if (obs !== 10'b1000_0000_00) begin failures++; $display("FAIL mid_async obs=%b exp=%b", obs, 10'b1000_0000_00); end
    #1 reset = 0;
    req = 4'b1000;
    step;
    req = 0; ack = 1;
    checks++;
    if (obs !== 10'b0100_1000_11) begin failures++; $display("FAIL mid_regrant obs=%b exp=%b", obs, 10'b0100_1000_11); end
    step;
    ack = 0;
    checks++;
    if (obs !== 10'b1000_0000_11) begin failures++; $display("FAIL mid_idle obs=%b exp=%b", obs, 10'b1000_0000_11); end
  endtask
  initial begin
    test_reset;
    test_single;
    test_round_robin;
    test_timeout;
    test_ack_wins;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
